// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encodings and the index-width helper live here so the top and the bench agree.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-bit index is still needed when only one slice position exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// master = upstream/downstream environment, slave = the adder itself.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry slice.
// Also exports the carry into bit 3 so the caller can form two's-complement overflow.
module nibble_add_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co,
    output logic       c3
);

    logic c;

    always_comb begin
        s4 = '0;
        c3 = 1'b0;
        c  = ci;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) c3 = c;
            s4[i] = a4[i] ^ b4[i] ^ c;
            c     = (a4[i] & b4[i]) | (c & (a4[i] ^ b4[i]));
        end
        co = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one 4-bit slice per clock, least-significant nibble first.
// state | meaning
// IDLE  | ready for operands; in_ready = 1
// RUN   | adding slice idx, carry held in register between slices
// DONE  | result valid, held until out_ready
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    nibble_serial_adder_if.slave bus
);

    localparam int W    = NIBBLE_W * NIBBLES;
    localparam int IDXW = idx_width(NIBBLES);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            ovf_r;

    logic [3:0] sl_a;
    logic [3:0] sl_b;
    logic [3:0] sl_s;
    logic       sl_co;
    logic       sl_c3;

    always_comb begin
        sl_a = op_a[idx*NIBBLE_W +: NIBBLE_W];
        sl_b = op_b[idx*NIBBLE_W +: NIBBLE_W];
    end

    nibble_add_slice u_slice (
        .a4 (sl_a),
        .b4 (sl_b),
        .ci (carry),
        .s4 (sl_s),
        .co (sl_co),
        .c3 (sl_c3)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.a;
                        op_b  <= bus.b;
                        carry <= bus.cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // sum is written in place; downstream only trusts it in DONE
                    sum_r[idx*NIBBLE_W +: NIBBLE_W] <= sl_s;
                    carry <= sl_co;
                    if (idx == LAST) begin
                        cout_r <= sl_co;
                        ovf_r  <= sl_c3 ^ sl_co;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
